mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Sequencer for the MEM stage of the pipelined CPU. It runs each data-memory access as a req/ack handshake and stalls the upstream pipeline registers until the access completes. While stalled, it injects a bubble into the MEM/WB register by zeroing that register's write-back controls. A programmable timeout stops a dead memory from hanging the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS-state cycles without `dmem_ack` before the access is abandoned; legal range 2..65535.
- CNT_W, 16: width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_read_in  in  1  EX/MEM control: current instruction loads.
- mem_write_in  in  1  EX/MEM control: current instruction stores.
- dmem_ack  in  1  memory completion; sampled only in ACCESS.
- err_clr  in  1  clears `timeout_err`.
- dmem_req  out  1  access request to data memory.
- dmem_we  out  1  write qualifier, valid while `dmem_req` is high.
- pipe_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- wb_bubble  out  1  force `mem_to_reg_in` and `reg_write_in` of MEM/WB to 0.
- timeout_err  out  1  sticky timeout flag.
- stall_count  out  32  stall-cycle counter (see Configuration).
- access_count  out  32  completed-access counter (see Configuration).

## Operation
The FSM has three states, one-hot or binary encoded per the package constants.
- **IDLE**
  - If `mem_write_in | mem_read_in`: latch `we_q <= mem_write_in`, clear the wait counter, go to ACCESS.
  - If both inputs are high, the access is a write (`we_q = 1`).
- **ACCESS**
  - `dmem_req = 1` and `dmem_we = we_q`.
  - On `dmem_ack`: go to IDLE and increment `access_count`.
  - Otherwise, if wait_cnt == TIMEOUT_CYCLES-1: go to ERR and set `timeout_err`.
  - Otherwise: increment wait_cnt.
  - If `dmem_ack` arrives in the same cycle as the timeout, `dmem_ack` wins; there is no error.
- **ERR**: lasts exactly 1 cycle, then goes to IDLE unconditionally. The instruction is squashed: it leaves the MEM stage without write-back.

Combinational outputs:
- `pipe_stall = (IDLE & (mem_read_in|mem_write_in)) | (ACCESS & ~dmem_ack)`.
- `wb_bubble = pipe_stall | ERR`.
- `dmem_req = ACCESS`. No request is issued from IDLE.
- Read data flows from memory straight into MEM/WB during the ack cycle. The controller holds no data path.

Error flag and counters:
- `timeout_err` stays set until a cycle with `err_clr = 1`.
- If set and clear happen in the same cycle, set wins.
- `stall_count` increments every cycle that `pipe_stall = 1`.
- Both counters wrap modulo 2^32.

## Timing
- Reset values: state IDLE, `we_q = 0`, wait_cnt 0, `dmem_req = 0`, `dmem_we = 0`, `timeout_err = 0`, both counters 0.
  - `pipe_stall` and `wb_bubble` are combinational from state and inputs.
- Reset asserted mid-ACCESS: `dmem_req` drops in the cycle after the reset edge. The access is abandoned with no error flagged.
- Memory-op latency: 1 IDLE stall cycle + N ACCESS cycles, where `dmem_ack` arrives in ACCESS cycle N (N ≥ 1).
  - Minimum is 2 cycles in MEM, i.e. 1 stall cycle.
  - The pipeline advances on the edge that ends the ack cycle.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after the ack. There is no idle gap beyond the mandatory IDLE cycle.
- Non-memory instructions pass through with 0 added cycles: `pipe_stall = 0`, `wb_bubble = 0`.
- Timeout: ERR is entered after exactly TIMEOUT_CYCLES ACCESS cycles without ack.

## Configuration
- `MEM_STAGE_CTRL_PERF_EN` defined: `stall_count` and `access_count` are implemented as described.
- Undefined: both outputs are tied to 32'd0 and no counter flops are synthesized. FSM behaviour is identical either way.

## Structure
- Package `cpu_pipe_pkg` holds:
  - the state encoding constants (ST_IDLE, ST_ACCESS, ST_ERR);
  - the shared control-field widths.
- One sub-module is natural: `wait_timer`.
  - It owns the CNT_W counter, with clear, enable and expired outputs.
  - Expired is high when the count equals TIMEOUT_CYCLES-1.
  - It is reusable for future instruction-fetch wait states.

## Test plan
- **Reset** (`reset = 0` for 2 cycles, ops pending): all registered outputs 0 and state IDLE; afterwards, a non-memory instruction gives `pipe_stall = 0`.
- **Load, 3-cycle ack** (`mem_read_in = 1`, `dmem_ack` in ACCESS cycle 3): `pipe_stall` high for 3 cycles, `dmem_we = 0`, `wb_bubble` high for those 3 cycles and low in the ack cycle; `access_count = 1`, `stall_count = 3`.
- **Simultaneous read and write** (both high, ack in cycle 1): `dmem_we = 1` throughout the request; 1 stall cycle.
- **Timeout** (TIMEOUT_CYCLES = 4, no ack): `dmem_req` high for exactly 4 cycles, then 1 ERR cycle with `pipe_stall = 0`, `wb_bubble = 1`; `timeout_err = 1` until `err_clr`.
- **Ack at the timeout boundary** (ack in ACCESS cycle 4 with TIMEOUT_CYCLES = 4): normal completion, `timeout_err` stays 0. Also, `err_clr` coinciding with a new timeout leaves `timeout_err = 1`.
- **Reset mid-ACCESS** (reset at ACCESS cycle 2): `dmem_req = 0` the next cycle, state IDLE, `timeout_err = 0`.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions: MEM-stage state encoding and control widths.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  localparam int CTRL_W = 1;
  localparam int PERF_W = 32;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter with clear/enable; expired flags the last allowed wait cycle.
module wait_timer
  import cpu_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: cleared outside a wait, counts up while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage req/ack sequencer with stall, write-back bubble and access timeout.
// Optional performance counters are built when MEM_STAGE_CTRL_PERF_EN is defined.
module mem_stage_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        dmem_ack,
  input  logic        err_clr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pipe_stall,
  output logic        wb_bubble,
  output logic        timeout_err,
  output logic [31:0] stall_count,
  output logic [31:0] access_count
);

  state_e state_r, state_nxt;
  logic   we_r, we_nxt;
  logic   req_r, dmem_we_r, err_r;
  logic   timer_clr_s, timer_en_s, expired_s, err_set_s, stall_s, mem_op_s;

  assign mem_op_s = is_mem_op(mem_read_in, mem_write_in);

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr_s),
    .en     (timer_en_s),
    .expired(expired_s)
  );

  // Next-state and stall decode; ack takes priority over the timeout.
  always_comb begin
    state_nxt   = state_r;
    we_nxt      = we_r;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    err_set_s   = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        if (mem_op_s) begin
          state_nxt = ST_ACCESS;
          we_nxt    = mem_write_in;
          stall_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_nxt = ST_IDLE;
        end else if (expired_s) begin
          state_nxt = ST_ERR;
          err_set_s = 1'b1;
          stall_s   = 1'b1;
        end else begin
          timer_en_s = 1'b1;
          stall_s    = 1'b1;
        end
      end
      ST_ERR: begin
        state_nxt   = ST_IDLE;
        timer_clr_s = 1'b1;
      end
      default: begin
        state_nxt   = ST_IDLE;
        timer_clr_s = 1'b1;
      end
    endcase
  end

  // State, request outputs and sticky error flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      we_r      <= 1'b0;
      req_r     <= 1'b0;
      dmem_we_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      we_r      <= we_nxt;
      req_r     <= (state_nxt == ST_ACCESS);
      dmem_we_r <= (state_nxt == ST_ACCESS) & we_nxt;
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign dmem_req    = req_r;
  assign dmem_we     = dmem_we_r;
  assign timeout_err = err_r;
  assign pipe_stall  = stall_s;
  assign wb_bubble   = stall_s | (state_r == ST_ERR);

`ifdef MEM_STAGE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_r, access_cnt_r;
  logic              ack_done_s;

  assign ack_done_s = (state_r == ST_ACCESS) & dmem_ack;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r  <= 32'd0;
      access_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r  <= stall_cnt_r + {31'd0, stall_s};
      access_cnt_r <= access_cnt_r + {31'd0, ack_done_s};
    end
  end

  assign stall_count  = stall_cnt_r;
  assign access_count = access_cnt_r;
`else
  assign stall_count  = 32'd0;
  assign access_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed, table-driven bench for mem_stage_ctrl with TIMEOUT_CYCLES = 4.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset, mem_read_in, mem_write_in, dmem_ack, err_clr;
  logic        dmem_req, dmem_we, pipe_stall, wb_bubble, timeout_err;
  logic [31:0] stall_count, access_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst_n, rd, wr, ack, clr, chk;
    logic req, we, stall, bub, err;
    int   acc, stc;
  } vec_t;

  vec_t vecs[$];

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_in (mem_read_in),
    .mem_write_in(mem_write_in),
    .dmem_ack    (dmem_ack),
    .err_clr     (err_clr),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .pipe_stall  (pipe_stall),
    .wb_bubble   (wb_bubble),
    .timeout_err (timeout_err),
    .stall_count (stall_count),
    .access_count(access_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] perf(input int v);
`ifdef MEM_STAGE_CTRL_PERF_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, rd, wr, ack, clr, chk, req, we, st, bb, er, input int acc, stc);
    vec_t v;
    v = '{rst_n: r, rd: rd, wr: wr, ack: ack, clr: clr, chk: chk,
          req: req, we: we, stall: st, bub: bb, err: er, acc: acc, stc: stc};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, rd, wr, ack, clr);
    reset = r; mem_read_in = rd; mem_write_in = wr; dmem_ack = ack; err_clr = clr;
  endtask

  task automatic check_all(input int idx, input logic req, we, st, bb, er, input int acc, stc);
    check("dmem_req", idx, {31'd0, dmem_req}, {31'd0, req});
    check("dmem_we", idx, {31'd0, dmem_we}, {31'd0, we});
    check("pipe_stall", idx, {31'd0, pipe_stall}, {31'd0, st});
    check("wb_bubble", idx, {31'd0, wb_bubble}, {31'd0, bb});
    check("timeout_err", idx, {31'd0, timeout_err}, {31'd0, er});
    check("access_count", idx, access_count, perf(acc));
    check("stall_count", idx, stall_count, perf(stc));
  endtask

  initial begin
    // reset with a load pending, then a non-memory instruction
    add(0,1,0,0,0,0, 0,0,0,0,0, 0,0);
    add(0,1,0,0,0,1, 0,0,1,1,0, 0,0);
    add(1,0,0,0,0,1, 0,0,0,0,0, 0,0);
    // load, ack in ACCESS cycle 3
    add(1,1,0,0,0,1, 0,0,1,1,0, 0,0);
    add(1,1,0,0,0,1, 1,0,1,1,0, 0,1);
    add(1,1,0,0,0,1, 1,0,1,1,0, 0,2);
    add(1,1,0,1,0,1, 1,0,0,0,0, 0,3);
    add(1,0,0,0,0,1, 0,0,0,0,0, 1,3);
    // read+write together is a write, ack in cycle 1
    add(1,1,1,0,0,1, 0,0,1,1,0, 1,3);
    add(1,1,1,1,0,1, 1,1,0,0,0, 1,4);
    add(1,0,0,0,0,1, 0,0,0,0,0, 2,4);
    // store with dead memory: 4 request cycles, ERR, sticky flag, clear
    add(1,0,1,0,0,1, 0,0,1,1,0, 2,4);
    for (int i = 0; i < 4; i++) add(1,0,1,0,0,1, 1,1,1,1,0, 2,5+i);
    add(1,0,0,0,0,1, 0,0,0,1,1, 2,9);
    add(1,0,0,0,0,1, 0,0,0,0,1, 2,9);
    add(1,0,0,0,1,1, 0,0,0,0,1, 2,9);
    add(1,0,0,0,0,1, 0,0,0,0,0, 2,9);
    // ack exactly at the timeout boundary
    add(1,1,0,0,0,1, 0,0,1,1,0, 2,9);
    for (int i = 0; i < 3; i++) add(1,1,0,0,0,1, 1,0,1,1,0, 2,10+i);
    add(1,1,0,1,0,1, 1,0,0,0,0, 2,13);
    add(1,0,0,0,0,1, 0,0,0,0,0, 3,13);
    // err_clr in the same cycle as a new timeout: set wins
    add(1,0,1,0,0,1, 0,0,1,1,0, 3,13);
    for (int i = 0; i < 3; i++) add(1,0,1,0,0,1, 1,1,1,1,0, 3,14+i);
    add(1,0,1,0,1,1, 1,1,1,1,0, 3,17);
    add(1,0,0,0,0,1, 0,0,0,1,1, 3,18);
    add(1,0,0,0,0,1, 0,0,0,0,1, 3,18);
    // reset asserted in ACCESS cycle 2
    add(1,1,0,0,0,1, 0,0,1,1,1, 3,18);
    add(1,1,0,0,0,1, 1,0,1,1,1, 3,19);
    add(0,1,0,0,0,1, 1,0,1,1,1, 3,20);
    add(1,0,0,0,0,1, 0,0,0,0,0, 0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rd, vecs[i].wr, vecs[i].ack, vecs[i].clr);
      #1;
      if (vecs[i].chk)
        check_all(i, vecs[i].req, vecs[i].we, vecs[i].stall, vecs[i].bub, vecs[i].err,
                  vecs[i].acc, vecs[i].stc);
      @(posedge clk);
      @(negedge clk);
    end

    // back-to-back: store acked in cycle 1, load seen in IDLE right after
    drive(1,0,1,0,0); #1; check_all(100, 0,0,1,1,0, 0,0); @(posedge clk); @(negedge clk);
    drive(1,0,1,1,0); #1; check_all(101, 1,1,0,0,0, 0,1); @(posedge clk); @(negedge clk);
    drive(1,1,0,0,0); #1; check_all(102, 0,0,1,1,0, 1,1); @(posedge clk); @(negedge clk);
    drive(1,1,0,1,0); #1; check_all(103, 1,0,0,0,0, 1,2); @(posedge clk); @(negedge clk);
    drive(1,0,0,0,0); #1; check_all(104, 0,0,0,0,0, 2,2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
